// File: rtl/current_ref_water.sv
// current_ref_water
// -----------------
// Converts a per-unit active-power reference and three phase voltages into
// three phase current references (IEEE-754 single precision):
//     I_x = P_ref * SBASE * V_x / max(Va^2 + Vb^2 + Vc^2, VSQ_MIN)
// One multiplier, one adder and one divider are shared and sequenced by an
// FSM. done_sig pulses exactly 2*MUL_LAT + 2*ADD_LAT + DIV_LAT + 6 cycles
// after an accepted sta.
//
// Ports:
//   clk, rst, rst_user        clock, synchronous active-high resets (equivalent)
//   sta                       start pulse, inputs sampled on this cycle in IDLE
//   P_ref, Va, Vb, Vc         float inputs (per-unit power, phase voltages)
//   Ia_ref, Ib_ref, Ic_ref    float current references, updated on done_sig
//   busy                      high from the cycle after sta through done_sig
//   vlow                      the VSQ_MIN floor was used in the last result
//   done_sig                  one-cycle pulse, results valid
//
// Optional feature: define CURRENT_LIMIT_EN to clamp each result magnitude
// to I_MAX (sign preserved) when the outputs are registered.
//
// Arithmetic: denormals flush to zero, round to nearest even, NaN/Inf are
// propagated without any special classification.
module current_ref_water #(
    parameter int          MUL_LAT = 5,
    parameter int          ADD_LAT = 7,
    parameter int          DIV_LAT = 6,
    parameter logic [31:0] SBASE   = 32'h49B71B00,
    parameter logic [31:0] VSQ_MIN = 32'h3C23D70A,
    parameter logic [31:0] I_MAX   = 32'h49C35000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_user,
    input  logic        sta,
    input  logic [31:0] P_ref,
    input  logic [31:0] Va,
    input  logic [31:0] Vb,
    input  logic [31:0] Vc,
    output logic [31:0] Ia_ref,
    output logic [31:0] Ib_ref,
    output logic [31:0] Ic_ref,
    output logic        busy,
    output logic        vlow,
    output logic        done_sig
);

    localparam logic [3:0] S_IDLE  = 4'd0, S_MUL1 = 4'd1, S_ADD1 = 4'd2,
                           S_ADD2  = 4'd3, S_CLAMP = 4'd4, S_DIV = 4'd5,
                           S_MUL2  = 4'd6, S_OUT  = 4'd7, S_DONE = 4'd8;

    function automatic logic [31:0] round_pack(input logic s, input logic signed [10:0] e,
                                               input logic [23:0] m, input logic g, input logic st);
        logic [24:0]        mr;
        logic signed [10:0] er;
        mr = {1'b0, m} + {24'b0, g & (st | m[0])};
        er = e;
        if (mr[24]) begin
            mr = mr >> 1;
            er = er + 11'sd1;
        end
        if (er >= 11'sd255) return {s, 8'hFF, 23'b0};
        if (er <= 11'sd0)   return {s, 31'b0};
        return {s, er[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        p;
        logic signed [10:0] e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, a[22:0] | b[22:0]};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'b0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = $signed({3'b0, a[30:23]}) + $signed({3'b0, b[30:23]}) - 11'sd127;
        if (p[47]) return round_pack(s, e + 11'sd1, p[47:24], p[23], |p[22:0]);
        return round_pack(s, e, p[46:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]        a, b;
        logic [7:0]         d;
        logic [49:0]        ma, mb, mbs;
        logic [50:0]        r;
        logic [5:0]         lz;
        logic signed [10:0] e;
        if (x[30:23] == 8'hFF) return x;
        if (y[30:23] == 8'hFF) return y;
        if (x[30:23] == 8'h00) return (y[30:23] == 8'h00) ? {x[31] & y[31], 31'b0} : y;
        if (y[30:23] == 8'h00) return x;
        // a is the operand with the larger magnitude
        if (x[30:0] >= y[30:0]) begin a = x; b = y; end
        else                    begin a = y; b = x; end
        d  = a[30:23] - b[30:23];
        ma = {1'b1, a[22:0], 26'b0};
        mb = {1'b1, b[22:0], 26'b0};
        if (d > 8'd49) mbs = 50'd1;
        else begin
            mbs    = mb >> d;
            // bits shifted out survive as a sticky LSB so rounding stays exact
            mbs[0] = mbs[0] | ((mbs << d) != mb);
        end
        r = (a[31] == b[31]) ? {1'b0, ma} + {1'b0, mbs} : {1'b0, ma} - {1'b0, mbs};
        if (r == 51'd0) return 32'b0;
        lz = 6'd0;
        for (int i = 0; i < 50; i++) begin
            if (!r[50]) begin
                r  = r << 1;
                lz = lz + 6'd1;
            end
        end
        e = $signed({3'b0, a[30:23]}) + 11'sd1 - $signed({5'b0, lz});
        return round_pack(a[31], e, r[50:27], r[26], |r[25:0]);
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [49:0]        num, den, q, rem;
        logic signed [10:0] e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, a[22:0] | b[22:0]};
        if (b[30:23] == 8'h00) return {s, 8'hFF, 23'b0};
        if (a[30:23] == 8'h00) return {s, 31'b0};
        num = {1'b1, a[22:0], 26'b0};
        den = 50'({1'b1, b[22:0]});
        q   = num / den;
        rem = num % den;
        e   = $signed({3'b0, a[30:23]}) - $signed({3'b0, b[30:23]}) + 11'sd127;
        if (q[26]) return round_pack(s, e, q[26:3], q[2], (|q[1:0]) | (rem != 50'd0));
        return round_pack(s, e - 11'sd1, q[25:2], q[1], q[0] | (rem != 50'd0));
    endfunction

`ifdef CURRENT_LIMIT_EN
    function automatic logic [31:0] limit(input logic [31:0] x);
        return (x[30:0] > I_MAX[30:0]) ? {x[31], I_MAX[30:0]} : x;
    endfunction
`else
    function automatic logic [31:0] limit(input logic [31:0] x);
        return x;
    endfunction
`endif

    logic [3:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d, vlow_q, vlow_d, vlow_pend_q, vlow_pend_d;
    logic [31:0] ia_ref_q, ia_ref_d, ib_ref_q, ib_ref_d, ic_ref_q, ic_ref_d;
    logic [31:0] p_ref_q, p_ref_d, va_q, va_d, vb_q, vb_d, vc_q, vc_d;
    logic [31:0] sqa_q, sqa_d, sqc_q, sqc_d, pw_q, pw_d, iam_q, iam_d, ibm_q, ibm_d;
    logic [31:0] k_q, k_d, div_den_q, div_den_d;

    // Issue-side operands of the shared cores (always enabled)
    logic        mul_vld;
    logic [2:0]  mul_tag;
    logic [31:0] mul_a, mul_b, add_a, add_b, div_a, div_b;

    logic [31:0]        mul_pipe_q [MUL_LAT];
    logic [2:0]         mul_tag_q  [MUL_LAT];
    logic [MUL_LAT-1:0] mul_vld_q;
    logic [31:0]        add_pipe_q [ADD_LAT];
    logic [31:0]        div_pipe_q [DIV_LAT];

    logic [31:0] mul_out, add_out, div_out;
    assign mul_out = mul_pipe_q[MUL_LAT-1];
    assign add_out = add_pipe_q[ADD_LAT-1];
    assign div_out = div_pipe_q[DIV_LAT-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
        busy_d = busy_q; done_d = 1'b0; vlow_d = vlow_q; vlow_pend_d = vlow_pend_q;
        ia_ref_d = ia_ref_q; ib_ref_d = ib_ref_q; ic_ref_d = ic_ref_q;
        p_ref_d = p_ref_q; va_d = va_q; vb_d = vb_q; vc_d = vc_q;
        sqa_d = sqa_q; sqc_d = sqc_q; pw_d = pw_q; iam_d = iam_q; ibm_d = ibm_q;
        k_d = k_q; div_den_d = div_den_q;
        mul_vld = 1'b0; mul_tag = 3'd0; mul_a = 32'b0; mul_b = 32'b0;
        add_a = 32'b0; add_b = 32'b0; div_a = 32'b0; div_b = 32'b0;

        // Products are steered to holding registers by the tag they were issued with:
        // 0 Va^2, 1 Vb^2 (used straight off the pipe), 2 Vc^2, 3 P*Sbase, 4 Ia, 5 Ib, 6 Ic
        if (mul_vld_q[MUL_LAT-1]) begin
            case (mul_tag_q[MUL_LAT-1])
                3'd0:    sqa_d = mul_out;
                3'd2:    sqc_d = mul_out;
                3'd3:    pw_d  = mul_out;
                3'd4:    iam_d = mul_out;
                3'd5:    ibm_d = mul_out;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: if (sta) begin
                p_ref_d = P_ref; va_d = Va; vb_d = Vb; vc_d = Vc;
                state_d = S_MUL1; cnt_d = 8'd3; busy_d = 1'b1;
            end
            S_MUL1: begin
                mul_vld = 1'b1;
                mul_tag = 3'd3 - cnt_q[2:0];
                case (cnt_q[1:0])
                    2'd3:    begin mul_a = va_q;    mul_b = va_q;  end
                    2'd2:    begin mul_a = vb_q;    mul_b = vb_q;  end
                    2'd1:    begin mul_a = vc_q;    mul_b = vc_q;  end
                    default: begin mul_a = p_ref_q; mul_b = SBASE; end
                endcase
                if (cnt_q == 8'd0) begin state_d = S_ADD1; cnt_d = 8'(MUL_LAT - 3); end
            end
            S_ADD1: if (cnt_q == 8'd0) begin
                add_a = sqa_q; add_b = mul_out;
                state_d = S_ADD2; cnt_d = 8'(ADD_LAT - 1);
            end
            S_ADD2: if (cnt_q == 8'd0) begin
                add_a = add_out; add_b = sqc_q;
                state_d = S_CLAMP; cnt_d = 8'(ADD_LAT - 1);
            end
            S_CLAMP: if (cnt_q == 8'd0) begin
                // Both operands are non-negative floats, so an unsigned compare orders them
                if (add_out < VSQ_MIN) begin div_den_d = VSQ_MIN; vlow_pend_d = 1'b1; end
                else                   begin div_den_d = add_out; vlow_pend_d = 1'b0; end
                state_d = S_DIV; cnt_d = 8'(DIV_LAT);
            end
            S_DIV: begin
                if (cnt_q == 8'(DIV_LAT)) begin div_a = pw_q; div_b = div_den_q; end
                // k is used straight off the divider for Ia, then held for Ib and Ic
                if (cnt_q == 8'd0) begin
                    k_d = div_out;
                    mul_vld = 1'b1; mul_tag = 3'd4; mul_a = div_out; mul_b = va_q;
                    state_d = S_MUL2; cnt_d = 8'd1;
                end
            end
            S_MUL2: begin
                mul_vld = 1'b1; mul_a = k_q;
                if (cnt_q == 8'd1) begin mul_tag = 3'd5; mul_b = vb_q; end
                else begin
                    mul_tag = 3'd6; mul_b = vc_q;
                    state_d = S_OUT; cnt_d = 8'(MUL_LAT - 1);
                end
            end
            S_OUT: if (cnt_q == 8'd0) begin
                ia_ref_d = limit(iam_q); ib_ref_d = limit(ibm_q); ic_ref_d = limit(mul_out);
                vlow_d = vlow_pend_q; done_d = 1'b1; state_d = S_DONE;
            end
            S_DONE: begin state_d = S_IDLE; busy_d = 1'b0; end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || rst_user) begin
            state_q <= S_IDLE; cnt_q <= 8'd0;
            busy_q <= 1'b0; done_q <= 1'b0; vlow_q <= 1'b0; vlow_pend_q <= 1'b0;
            ia_ref_q <= 32'b0; ib_ref_q <= 32'b0; ic_ref_q <= 32'b0;
            mul_vld_q <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d;
            busy_q <= busy_d; done_q <= done_d; vlow_q <= vlow_d; vlow_pend_q <= vlow_pend_d;
            ia_ref_q <= ia_ref_d; ib_ref_q <= ib_ref_d; ic_ref_q <= ic_ref_d;
            mul_vld_q <= {mul_vld_q[MUL_LAT-2:0], mul_vld};
        end
    end

    always_ff @(posedge clk) begin
        p_ref_q <= p_ref_d; va_q <= va_d; vb_q <= vb_d; vc_q <= vc_d;
        sqa_q <= sqa_d; sqc_q <= sqc_d; pw_q <= pw_d; iam_q <= iam_d; ibm_q <= ibm_d;
        k_q <= k_d; div_den_q <= div_den_d;
        mul_pipe_q[0] <= fmul(mul_a, mul_b);
        mul_tag_q[0]  <= mul_tag;
        add_pipe_q[0] <= fadd(add_a, add_b);
        div_pipe_q[0] <= fdiv(div_a, div_b);
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_pipe_q[i] <= mul_pipe_q[i-1];
            mul_tag_q[i]  <= mul_tag_q[i-1];
        end
        for (int i = 1; i < ADD_LAT; i++) add_pipe_q[i] <= add_pipe_q[i-1];
        for (int i = 1; i < DIV_LAT; i++) div_pipe_q[i] <= div_pipe_q[i-1];
    end

    assign Ia_ref   = ia_ref_q;
    assign Ib_ref   = ib_ref_q;
    assign Ic_ref   = ic_ref_q;
    assign busy     = busy_q;
    assign vlow     = vlow_q;
    assign done_sig = done_q;

endmodule

// File: doc/current_ref_water.md
Name: current_ref_water

Overview:
- Inverse of the three-phase power measurement path. Takes a per-unit active-power reference and the three phase voltages, and produces three phase current references (single-precision float) that deliver that power: I_x = P_ref*Sbase*V_x / (Va²+Vb²+Vc²).
- Sits between the water-turbine power controller output and the converter current loops.
- Uses one shared float multiplier, one adder and one divider, sequenced by an FSM with a sta/done_sig handshake.

Parameters:
- MUL_LAT, 5, latency in clocks of the Multiplier_nodsp_dsp instance.
- ADD_LAT, 7, latency in clocks of the Adder_nodsp instance.
- DIV_LAT, 6, latency in clocks of the float divider instance.
- SBASE, 32'h49B71B00, Sbase = 1.5e6 as a float.
- VSQ_MIN, 32'h3C23D70A, floor (0.01) applied to the sum of squares.
- I_MAX, 32'h49C35000, current magnitude limit of 1.6e6; used only with CURRENT_LIMIT_EN.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- rst_user, in, 1, synchronous active-high user reset; same effect as rst.
- sta, in, 1, start pulse; inputs are sampled on this cycle.
- P_ref, in, 32, power reference in per-unit (float).
- Va, in, 32, phase-a voltage (float).
- Vb, in, 32, phase-b voltage (float).
- Vc, in, 32, phase-c voltage (float).
- Ia_ref, out, 32, phase-a current reference (float).
- Ib_ref, out, 32, phase-b current reference (float).
- Ic_ref, out, 32, phase-c current reference (float).
- busy, out, 1, high from the cycle after sta is accepted through the done_sig cycle.
- vlow, out, 1, high when the VSQ_MIN floor was applied in the last computation.
- done_sig, out, 1, one-cycle pulse when all three outputs are valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, ports rst and rst_user.
- Reset values: all outputs are 0, the FSM is in IDLE, and the latency counter is 0.
- Reset mid-operation: the computation is aborted, nothing is committed and done_sig does not pulse.
- sta handling: sta in IDLE is accepted and the inputs are latched. sta while busy=1 is ignored, including on the done_sig cycle.
- FSM states and transitions:
  - IDLE.
  - MUL1: issues Va*Va, Vb*Vb, Vc*Vc and P_ref*SBASE on consecutive cycles 1..4 after sta.
  - ADD1: Va²+Vb² issued at cycle 2+MUL_LAT.
  - ADD2: +Vc² issued at cycle 2+MUL_LAT+ADD_LAT.
  - CLAMP: registered, 1 cycle. Sum compared with VSQ_MIN as an unsigned 32-bit compare (valid because both are non-negative). If sum < VSQ_MIN, the divisor is VSQ_MIN and vlow is set to 1; otherwise vlow is set to 0.
  - DIV: k = P_W/divisor.
  - MUL2: k*Va, k*Vb, k*Vc issued on 3 consecutive cycles.
  - OUT: outputs registered simultaneously.
  - DONE: done_sig pulses, then the FSM returns to IDLE.
- Step waits use one down-counter loaded with the relevant latency. No handshake exists on the arithmetic cores; they are always enabled.
- Fixed latency: done_sig asserts exactly LAT = 2*MUL_LAT + 2*ADD_LAT + DIV_LAT + 6 cycles after sta (36 with defaults).
- Output holding: outputs hold their values between computations and change only on the done_sig cycle. vlow updates on the done_sig cycle.
- Special values: zero voltages give signed-zero outputs. P_ref negative gives currents of inverted sign. NaN/Inf are passed through, unchecked.
- Back-to-back operation: sta arriving the cycle after done_sig is accepted normally.

Optional Feature:
- CURRENT_LIMIT_EN defined: in the OUT state each result whose magnitude bits [30:0] exceed I_MAX[30:0] is replaced by {sign, I_MAX[30:0]}. The sign is kept. Latency is unchanged.
- CURRENT_LIMIT_EN undefined: results pass unmodified, and I_MAX is unused.

Test Plan:
- Nominal: P_ref=3F800000, Va=3F800000, Vb=BF000000, Vc=BF000000, sta pulse -> done_sig at cycle 36 with Ia_ref=49742400, Ib_ref=C8F42400, Ic_ref=C8F42400, vlow=0.
- Low voltage: P_ref=3C23D70A, Va=3D4CCCCD (0.05), Vb=Vc=0 -> floor applied, vlow=1, Ia_ref≈47927C00 (±2 ulp), Ib_ref=Ic_ref=±0.
- Busy: second sta at cycle 10 with different inputs -> ignored. Single done_sig at cycle 36 with the first result. busy is high on cycles 1..36.
- Reset mid-op: rst high at cycle 20 -> outputs 0, no done_sig. A new sta at cycle 25 gives done_sig at cycle 61.
- Limit (CURRENT_LIMIT_EN defined): nominal voltages, P_ref=40000000 -> Ia_ref=49C35000 (clamped), Ib_ref=Ic_ref=C9742400. Without the macro, Ia_ref=49F42400.
- Back-to-back: sta at cycle 0 and at cycle 37 -> two done_sig pulses, at cycles 36 and 73.
